// File: rtl/status_monitor.sv
// Run monitor for the core's retired-status stream: counts R/I-type instructions and RUN cycles,
// and latches a sticky verdict (done, overflow fault or watchdog timeout) until the next start.
module status_monitor #(
  parameter int CNT_W      = 32,
  parameter int WDOG_W     = 16,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [1:0]       i_status,
  input  logic             i_status_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_r_cnt,
  output logic [CNT_W-1:0] o_i_cnt,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [1:0]       o_last_status
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [1:0] ST_R_TYPE   = 2'd0;
  localparam logic [1:0] ST_I_TYPE   = 2'd1;
  localparam logic [1:0] ST_OVERFLOW = 2'd2;
  localparam logic [1:0] ST_END      = 2'd3;

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;
  logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [1:0]        last_status_q, last_status_d;

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = done_q;
    overflow_d    = overflow_q;
    timeout_d     = timeout_q;
    r_cnt_d       = r_cnt_q;
    i_cnt_d       = i_cnt_q;
    cycle_cnt_d   = cycle_cnt_q;
    wdog_d        = wdog_q;
    last_status_d = last_status_q;

    case (state_q)
      S_RUN: begin
        cycle_cnt_d = (cycle_cnt_q == CNT_MAX) ? cycle_cnt_q : cycle_cnt_q + CNT_ONE;
        if (i_status_valid) begin
          // A valid status always feeds the watchdog, even on the cycle it would have expired.
          last_status_d = i_status;
          wdog_d        = '0;
          case (i_status)
            ST_R_TYPE: r_cnt_d = (r_cnt_q == CNT_MAX) ? r_cnt_q : r_cnt_q + CNT_ONE;
            ST_I_TYPE: i_cnt_d = (i_cnt_q == CNT_MAX) ? i_cnt_q : i_cnt_q + CNT_ONE;
            ST_OVERFLOW: begin
              state_d    = S_FAULT;
              busy_d     = 1'b0;
              overflow_d = 1'b1;
            end
            ST_END: begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
            default: ;
          endcase
        end else if (wdog_q == WDOG_LAST) begin
          state_d   = S_FAULT;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      default: begin
        // IDLE, DONE and FAULT all wait for a start; status traffic is ignored here.
        if (i_start) begin
          state_d       = S_RUN;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          overflow_d    = 1'b0;
          timeout_d     = 1'b0;
          r_cnt_d       = '0;
          i_cnt_d       = '0;
          cycle_cnt_d   = '0;
          wdog_d        = '0;
          last_status_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_q     <= 1'b0;
      r_cnt_q       <= '0;
      i_cnt_q       <= '0;
      cycle_cnt_q   <= '0;
      wdog_q        <= '0;
      last_status_q <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      timeout_q     <= timeout_d;
      r_cnt_q       <= r_cnt_d;
      i_cnt_q       <= i_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
      wdog_q        <= wdog_d;
      last_status_q <= last_status_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_overflow    = overflow_q;
  assign o_timeout     = timeout_q;
  assign o_r_cnt       = r_cnt_q;
  assign o_i_cnt       = i_cnt_q;
  assign o_cycle_cnt   = cycle_cnt_q;
  assign o_last_status = last_status_q;

endmodule

// File: tb/tb_status_monitor.sv
// Directed bench for status_monitor: a per-cycle vector table plus hand sequences for
// watchdog expiry/feeding and counter saturation (8-bit and 3-bit instances share stimulus).
module tb_status_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic [1:0] status = 2'd0;

  logic       busy, done, ovf, tmo;
  logic [7:0] r_cnt, i_cnt, cyc_cnt;
  logic [1:0] last;

  logic       busy3, done3, ovf3, tmo3;
  logic [2:0] r_cnt3, i_cnt3, cyc_cnt3;
  logic [1:0] last3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  status_monitor #(.CNT_W(8), .WDOG_W(16), .WDOG_LIMIT(8)) dut (
    .clk(clk), .reset(rst), .i_start(start), .i_status(status), .i_status_valid(valid),
    .o_busy(busy), .o_done(done), .o_overflow(ovf), .o_timeout(tmo),
    .o_r_cnt(r_cnt), .o_i_cnt(i_cnt), .o_cycle_cnt(cyc_cnt), .o_last_status(last)
  );

  status_monitor #(.CNT_W(3), .WDOG_W(16), .WDOG_LIMIT(8)) dut3 (
    .clk(clk), .reset(rst), .i_start(start), .i_status(status), .i_status_valid(valid),
    .o_busy(busy3), .o_done(done3), .o_overflow(ovf3), .o_timeout(tmo3),
    .o_r_cnt(r_cnt3), .o_i_cnt(i_cnt3), .o_cycle_cnt(cyc_cnt3), .o_last_status(last3)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic       valid;
    logic [1:0] status;
    logic       busy, done, ovf, tmo;
    logic [7:0] r, i, cyc;
    logic [1:0] last;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic r_, s_, v_, input logic [1:0] st_,
                              input logic b_, d_, o_, t_,
                              input logic [7:0] rc_, ic_, cc_, input logic [1:0] l_);
    vec_t v;
    v.rst = r_; v.start = s_; v.valid = v_; v.status = st_;
    v.busy = b_; v.done = d_; v.ovf = o_; v.tmo = t_;
    v.r = rc_; v.i = ic_; v.cyc = cc_; v.last = l_;
    return v;
  endfunction

  function automatic logic [29:0] pk(input logic b_, d_, o_, t_,
                                     input logic [7:0] rc_, ic_, cc_, input logic [1:0] l_);
    return {b_, d_, o_, t_, rc_, ic_, cc_, l_};
  endfunction

  task automatic step(input logic r_, s_, v_, input logic [1:0] st_);
    rst = r_; start = s_; valid = v_; status = st_;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [29:0] got, input logic [29:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  initial begin
    // rst start valid status | busy done ovf tmo | r i cyc last
    tbl[0]  = mk(1,0,0,0, 0,0,0,0, 0,0,0,0);  // reset
    tbl[1]  = mk(0,1,0,0, 1,0,0,0, 0,0,0,0);  // start
    tbl[2]  = mk(0,0,1,0, 1,0,0,0, 1,0,1,0);
    tbl[3]  = mk(0,0,1,1, 1,0,0,0, 1,1,2,1);
    tbl[4]  = mk(0,0,1,0, 1,0,0,0, 2,1,3,0);
    tbl[5]  = mk(0,0,1,0, 1,0,0,0, 3,1,4,0);
    tbl[6]  = mk(0,0,1,3, 0,1,0,0, 3,1,5,3);  // MIPS_END -> DONE
    tbl[7]  = mk(0,0,1,0, 0,1,0,0, 3,1,5,3);  // ignored in DONE
    tbl[8]  = mk(0,1,0,0, 1,0,0,0, 0,0,0,0);  // restart from DONE clears
    tbl[9]  = mk(0,0,1,1, 1,0,0,0, 0,1,1,1);
    tbl[10] = mk(0,0,1,2, 0,0,1,0, 0,1,2,2);  // overflow fault
    tbl[11] = mk(0,0,1,0, 0,0,1,0, 0,1,2,2);  // ignored in FAULT
    tbl[12] = mk(1,0,0,0, 0,0,0,0, 0,0,0,0);
    tbl[13] = mk(0,1,1,3, 1,0,0,0, 0,0,0,0);  // start+END in IDLE: END ignored
    tbl[14] = mk(0,0,1,0, 1,0,0,0, 1,0,1,0);
    tbl[15] = mk(0,0,1,0, 1,0,0,0, 2,0,2,0);
    tbl[16] = mk(0,0,1,0, 1,0,0,0, 3,0,3,0);
    tbl[17] = mk(0,0,1,0, 1,0,0,0, 4,0,4,0);
    tbl[18] = mk(1,1,1,0, 0,0,0,0, 0,0,0,0);  // reset mid-run wins over start/valid
    tbl[19] = mk(0,0,1,3, 0,0,0,0, 0,0,0,0);  // IDLE without start ignores status
    tbl[20] = mk(0,0,1,0, 0,0,0,0, 0,0,0,0);

    for (int k = 0; k < 21; k++) begin
      step(tbl[k].rst, tbl[k].start, tbl[k].valid, tbl[k].status);
      check($sformatf("vec%0d", k),
            pk(busy, done, ovf, tmo, r_cnt, i_cnt, cyc_cnt, last),
            pk(tbl[k].busy, tbl[k].done, tbl[k].ovf, tbl[k].tmo,
               tbl[k].r, tbl[k].i, tbl[k].cyc, tbl[k].last));
    end

    // Watchdog expires on the 8th consecutive idle RUN cycle.
    step(0, 1, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0);
      check($sformatf("wdog_idle%0d", k),
            pk(busy, done, ovf, tmo, r_cnt, i_cnt, cyc_cnt, last),
            pk(k < 8, 1'b0, 1'b0, k == 8, 8'd0, 8'd0, 8'(k), 2'd0));
    end

    // A valid status on idle cycle 7 feeds the watchdog; expiry moves to cycle 15.
    step(0, 1, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      step(0, 0, k == 7, 2'd0);
      if (k >= 6 && k != 10 && k != 11 && k != 12)
        check($sformatf("wdog_fed%0d", k),
              pk(busy, done, ovf, tmo, r_cnt, i_cnt, cyc_cnt, last),
              pk(k < 15, 1'b0, 1'b0, k == 15, (k >= 7) ? 8'd1 : 8'd0, 8'd0, 8'(k), 2'd0));
    end

    // Saturation: 9 R_TYPE statuses, 3-bit counters clamp at 7.
    step(0, 1, 0, 0);
    for (int k = 0; k < 9; k++) step(0, 0, 1, 2'd0);
    check("sat_w8", pk(busy, done, ovf, tmo, r_cnt, i_cnt, cyc_cnt, last),
          pk(1'b1, 1'b0, 1'b0, 1'b0, 8'd9, 8'd0, 8'd9, 2'd0));
    check("sat_w3", pk(busy3, done3, ovf3, tmo3, {5'd0, r_cnt3}, {5'd0, i_cnt3}, {5'd0, cyc_cnt3}, last3),
          pk(1'b1, 1'b0, 1'b0, 1'b0, 8'd7, 8'd0, 8'd7, 2'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
